// File: rtl/pong_pkg.sv
// Shared pong playfield geometry, ball FSM encoding and helpers for the
// 15-bit signed arithmetic used by the ball physics.
package pong_pkg;

    localparam int COORD_W = 13;
    localparam int SW      = 15;
    localparam int SPD_W   = 6;
    localparam int HOLD_W  = 6;

    localparam logic [COORD_W-1:0] FIELD_W    = 13'd2560;
    localparam logic [COORD_W-1:0] FIELD_H    = 13'd1920;
    localparam logic [COORD_W-1:0] BALL_R     = 13'd16;
    localparam logic [COORD_W-1:0] PADDLE_HW  = 13'd16;
    localparam logic [COORD_W-1:0] CENTER_X   = FIELD_W >> 1;
    localparam logic [COORD_W-1:0] CENTER_Y   = FIELD_H >> 1;
    localparam logic [COORD_W-1:0] COORD_ONE  = 13'd1;

    localparam logic [SPD_W-1:0]   SPEED_INIT = 6'd8;
    localparam logic [SPD_W-1:0]   SPEED_STEP = 6'd2;
    localparam logic [SPD_W-1:0]   SPEED_MAX  = 6'd32;

    localparam logic [HOLD_W-1:0]  HOLD_TICKS = 6'd60;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_TICKS - 6'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        SCORED = 2'd2
    } ball_state_t;

    function automatic logic signed [SW-1:0] coord_s(input logic [COORD_W-1:0] v);
        return signed'({{(SW-COORD_W){1'b0}}, v});
    endfunction

    function automatic logic signed [SW-1:0] speed_s(input logic [SPD_W-1:0] v);
        return signed'({{(SW-SPD_W){1'b0}}, v});
    endfunction

    // Folds a signed intermediate back into 0..limit-1 so outputs never wrap.
    function automatic logic [COORD_W-1:0] clamp_coord(input logic signed [SW-1:0] v,
                                                       input logic [COORD_W-1:0]   limit);
        if (v[SW-1])
            return '0;
        else if (v >= coord_s(limit))
            return limit - COORD_ONE;
        else
            return v[COORD_W-1:0];
    endfunction

    localparam logic signed [SW-1:0] S_ZERO      = '0;
    localparam logic signed [SW-1:0] S_BALL_R    = coord_s(BALL_R);
    localparam logic signed [SW-1:0] S_PADDLE_HW = coord_s(PADDLE_HW);
    localparam logic signed [SW-1:0] S_FIELD_W   = coord_s(FIELD_W);
    localparam logic signed [SW-1:0] S_FIELD_H   = coord_s(FIELD_H);
    localparam logic signed [SW-1:0] S_SPEED_Y   = speed_s(SPEED_INIT);

endpackage

// File: rtl/ball_paddle_hit.sv
// Crossing/overlap test for one paddle face: a hit is this frame's step carrying
// the ball's leading edge from clear of the face onto it while the paddle spans the ball in y.
module ball_paddle_hit
    import pong_pkg::*;
#(
    parameter bit RIGHT_SIDE = 1'b0
) (
    input  logic signed [SW-1:0] i_x,
    input  logic signed [SW-1:0] i_nx,
    input  logic signed [SW-1:0] i_y,
    input  logic signed [SW-1:0] i_pad_x,
    input  logic signed [SW-1:0] i_pad_y,
    input  logic signed [SW-1:0] i_pad_size,
    output logic                 o_hit,
    output logic signed [SW-1:0] o_contact_x
);

    logic signed [SW-1:0] w_face;
    logic signed [SW-1:0] w_dy;
    logic signed [SW-1:0] w_abs_dy;
    logic                 w_was_clear;
    logic                 w_reaches;
    logic                 w_overlap;

    always_comb begin
        w_dy      = i_y - i_pad_y;
        w_abs_dy  = w_dy[SW-1] ? -w_dy : w_dy;
        w_overlap = (w_abs_dy <= (i_pad_size + S_BALL_R));
        if (RIGHT_SIDE) begin
            w_face      = i_pad_x - S_PADDLE_HW;
            w_was_clear = (i_x + S_BALL_R) < w_face;
            w_reaches   = (i_nx + S_BALL_R) >= w_face;
            o_contact_x = w_face - S_BALL_R;
        end else begin
            w_face      = i_pad_x + S_PADDLE_HW;
            w_was_clear = (i_x - S_BALL_R) > w_face;
            w_reaches   = (i_nx - S_BALL_R) <= w_face;
            o_contact_x = w_face + S_BALL_R;
        end
        o_hit = w_was_clear && w_reaches && w_overlap;
    end

endmodule

// File: rtl/ball_move.sv
// Ball physics: owns position, velocity and the serve/play/scored FSM; advances
// once per frame tick, resolving wall bounces, paddle hits and misses.
module ball_move
    import pong_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               serve,
    input  logic [COORD_W-1:0] paddle_l_x,
    input  logic [COORD_W-1:0] paddle_l_y,
    input  logic [COORD_W-1:0] paddle_r_x,
    input  logic [COORD_W-1:0] paddle_r_y,
    input  logic [COORD_W-1:0] paddle_size,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic               in_play,
    output logic               score_l,
    output logic               score_r
);

    ball_state_t          r_state, w_state;
    logic [COORD_W-1:0]   r_x, r_y, w_x, w_y;
    logic                 r_dir_x, r_dir_y, w_dir_x, w_dir_y;   // 1 = increasing coordinate
    logic [SPD_W-1:0]     r_speed, w_speed, w_speed_hit;
    logic [HOLD_W-1:0]    r_hold, w_hold;
    logic                 r_score_l, r_score_r, w_score_l, w_score_r;
    logic signed [SW-1:0] w_cx, w_cy, w_nx, w_ny, w_ry;
    logic                 w_ry_up;
    logic                 w_hit_l, w_hit_r;
    logic signed [SW-1:0] w_contact_l, w_contact_r;

    always_comb begin
        w_cx = coord_s(r_x);
        w_cy = coord_s(r_y);
        w_nx = r_dir_x ? (w_cx + speed_s(r_speed)) : (w_cx - speed_s(r_speed));
        w_ny = r_dir_y ? (w_cy + S_SPEED_Y) : (w_cy - S_SPEED_Y);
        if ((w_ny - S_BALL_R) <= S_ZERO) begin
            w_ry    = S_BALL_R;
            w_ry_up = 1'b1;
        end else if ((w_ny + S_BALL_R) >= S_FIELD_H) begin
            w_ry    = S_FIELD_H - S_BALL_R;
            w_ry_up = 1'b0;
        end else begin
            w_ry    = w_ny;
            w_ry_up = r_dir_y;
        end
        w_speed_hit = (r_speed >= (SPEED_MAX - SPEED_STEP)) ? SPEED_MAX : (r_speed + SPEED_STEP);
    end

    ball_paddle_hit #(.RIGHT_SIDE(1'b0)) u_hit_l (
        .i_x         (w_cx),
        .i_nx        (w_nx),
        .i_y         (w_ry),
        .i_pad_x     (coord_s(paddle_l_x)),
        .i_pad_y     (coord_s(paddle_l_y)),
        .i_pad_size  (coord_s(paddle_size)),
        .o_hit       (w_hit_l),
        .o_contact_x (w_contact_l)
    );

    ball_paddle_hit #(.RIGHT_SIDE(1'b1)) u_hit_r (
        .i_x         (w_cx),
        .i_nx        (w_nx),
        .i_y         (w_ry),
        .i_pad_x     (coord_s(paddle_r_x)),
        .i_pad_y     (coord_s(paddle_r_y)),
        .i_pad_size  (coord_s(paddle_size)),
        .o_hit       (w_hit_r),
        .o_contact_x (w_contact_r)
    );

    always_comb begin
        w_state   = r_state;
        w_x       = r_x;
        w_y       = r_y;
        w_dir_x   = r_dir_x;
        w_dir_y   = r_dir_y;
        w_speed   = r_speed;
        w_hold    = r_hold;
        w_score_l = 1'b0;
        w_score_r = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (serve) w_state = PLAY;
            end
            PLAY: begin
                if (tick) begin
                    w_y     = clamp_coord(w_ry, FIELD_H);
                    w_dir_y = w_ry_up;
                    if (!r_dir_x) begin
                        if (w_hit_l) begin
                            w_x     = clamp_coord(w_contact_l, FIELD_W);
                            w_dir_x = 1'b1;
                            w_speed = w_speed_hit;
                        end else if ((w_nx - S_BALL_R) <= S_ZERO) begin
                            w_x       = BALL_R;
                            w_score_r = 1'b1;
                            w_state   = SCORED;
                        end else begin
                            w_x = clamp_coord(w_nx, FIELD_W);
                        end
                    end else begin
                        if (w_hit_r) begin
                            w_x     = clamp_coord(w_contact_r, FIELD_W);
                            w_dir_x = 1'b0;
                            w_speed = w_speed_hit;
                        end else if ((w_nx + S_BALL_R) >= S_FIELD_W) begin
                            w_x       = FIELD_W - BALL_R;
                            w_score_l = 1'b1;
                            w_state   = SCORED;
                        end else begin
                            w_x = clamp_coord(w_nx, FIELD_W);
                        end
                    end
                end
            end
            SCORED: begin
                // dir_x still points at the side that missed, so the next serve heads there.
                if (tick) begin
                    if (r_hold == HOLD_LAST) begin
                        w_state = IDLE;
                        w_x     = CENTER_X;
                        w_y     = CENTER_Y;
                        w_speed = SPEED_INIT;
                        w_hold  = '0;
                    end else begin
                        w_hold = r_hold + HOLD_W'(1);
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_x       <= CENTER_X;
            r_y       <= CENTER_Y;
            r_dir_x   <= 1'b1;
            r_dir_y   <= 1'b1;
            r_speed   <= SPEED_INIT;
            r_hold    <= '0;
            r_score_l <= 1'b0;
            r_score_r <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_x       <= w_x;
            r_y       <= w_y;
            r_dir_x   <= w_dir_x;
            r_dir_y   <= w_dir_y;
            r_speed   <= w_speed;
            r_hold    <= w_hold;
            r_score_l <= w_score_l;
            r_score_r <= w_score_r;
        end
    end

    assign ball_x  = r_x;
    assign ball_y  = r_y;
    assign in_play = (r_state == PLAY);
    assign score_l = r_score_l;
    assign score_r = r_score_r;

endmodule

// File: tb/tb_ball_move.sv
// Directed bench for ball_move: serve, wall bounce, paddle hits with speed
// saturation, misses on both sides, the scored hold and async reset.
module tb_ball_move;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        serve;
    logic [12:0] paddle_l_x, paddle_l_y, paddle_r_x, paddle_r_y, paddle_size;
    logic [12:0] ball_x, ball_y;
    logic        in_play, score_l, score_r;

    int n_cmp = 0;
    int n_bad = 0;

    ball_move dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .serve       (serve),
        .paddle_l_x  (paddle_l_x),
        .paddle_l_y  (paddle_l_y),
        .paddle_r_x  (paddle_r_x),
        .paddle_r_y  (paddle_r_y),
        .paddle_size (paddle_size),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .in_play     (in_play),
        .score_l     (score_l),
        .score_r     (score_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_ball(input string tag, input int ex, input int ey);
        check({tag, "_x"}, 32'(ball_x), 32'(ex));
        check({tag, "_y"}, 32'(ball_y), 32'(ey));
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    task automatic serve_pulse();
        @(negedge clk);
        serve = 1'b1;
        @(negedge clk);
        serve = 1'b0;
    endtask

    task automatic sync_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; serve = 1'b0;
        paddle_l_x = 13'd100;  paddle_l_y = 13'd100;
        paddle_r_x = 13'd2400; paddle_r_y = 13'd1800;
        paddle_size = 13'd128;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check_ball("reset", 1280, 960);
        check("reset_in_play", 32'(in_play), 0);
        check("reset_score_l", 32'(score_l), 0);
        check("reset_score_r", 32'(score_r), 0);

        // Serve needs no tick; first tick moves +8/+8.
        serve_pulse();
        check("serve_in_play", 32'(in_play), 1);
        check_ball("serve_held", 1280, 960);
        do_ticks(1);
        check_ball("first_tick", 1288, 968);
        serve_pulse();
        check_ball("serve_in_play_ignored", 1288, 968);
        check("serve_in_play_state", 32'(in_play), 1);

        // Asynchronous reset between clock edges.
        #2 rst = 1'b1;
        #1;
        check_ball("async_reset", 1280, 960);
        check("async_reset_in_play", 32'(in_play), 0);
        check("async_reset_score_l", 32'(score_l), 0);
        @(negedge clk);
        rst = 1'b0;

        // Bottom wall bounce after 118 ticks.
        serve_pulse();
        do_ticks(117);
        check_ball("pre_wall", 2216, 1896);
        do_ticks(1);
        check_ball("wall_hit", 2224, 1904);
        do_ticks(1);
        check_ball("after_wall", 2232, 1896);

        // Right paddle hit at contact 2368, speed becomes 10.
        do_ticks(17);
        check_ball("right_hit", 2368, 1760);
        do_ticks(1);
        check_ball("after_right_hit", 2358, 1752);

        // Rally between close paddles until |vx| saturates at 32.
        paddle_l_x  = 13'd2200;
        paddle_size = 13'd4000;
        do_ticks(13);
        check("left_hit_x", 32'(ball_x), 2232);
        do_ticks(75);
        check("rally_x", 32'(ball_x), 2232);
        do_ticks(5);
        check("sat_hit_x", 32'(ball_x), 2368);
        do_ticks(1);
        check_ball("saturated_step", 2336, 1000);

        // Right miss: left paddle returns it, right paddle parked far in y.
        paddle_size = 13'd128;
        paddle_l_y  = 13'd960;
        paddle_r_y  = 13'd200;
        do_ticks(4);
        check_ball("return_hit", 2232, 968);
        do_ticks(9);
        check_ball("pre_miss_r", 2520, 896);
        check("pre_miss_r_score_l", 32'(score_l), 0);
        do_ticks(1);
        check_ball("miss_r", 2544, 888);
        check("miss_r_score_l", 32'(score_l), 1);
        check("miss_r_score_r", 32'(score_r), 0);
        check("miss_r_in_play", 32'(in_play), 0);
        @(negedge clk);
        check("miss_r_pulse_end", 32'(score_l), 0);
        serve_pulse();
        check("scored_serve_ignored", 32'(in_play), 0);
        do_ticks(59);
        check_ball("scored_frozen", 2544, 888);
        check("scored_single_pulse", 32'(score_l), 0);
        do_ticks(1);
        check_ball("scored_recentre", 1280, 960);
        check("scored_idle", 32'(in_play), 0);
        serve_pulse();
        check("reserve_in_play", 32'(in_play), 1);
        do_ticks(1);
        check("reserve_dir_right", 32'(ball_x), 1288);

        // Left miss with top-wall bounce on the way; x must clamp, not wrap.
        sync_reset();
        paddle_l_x = 13'd100;  paddle_l_y = 13'd1900;
        paddle_r_x = 13'd2400; paddle_r_y = 13'd1800;
        paddle_size = 13'd4000;
        check_ball("reset2", 1280, 960);
        serve_pulse();
        do_ticks(136);
        check_ball("right_hit2", 2368, 1760);
        paddle_size = 13'd16;
        do_ticks(235);
        check_ball("pre_miss_l", 18, 152);
        check("pre_miss_l_score_r", 32'(score_r), 0);
        do_ticks(1);
        check_ball("miss_l", 16, 160);
        check("miss_l_score_r", 32'(score_r), 1);
        check("miss_l_score_l", 32'(score_l), 0);
        @(negedge clk);
        check("miss_l_pulse_end", 32'(score_r), 0);
        do_ticks(60);
        check_ball("scored2_recentre", 1280, 960);
        serve_pulse();
        do_ticks(1);
        check("reserve_dir_left", 32'(ball_x), 1272);

        // Wall and right paddle on the same tick: both directions flip.
        sync_reset();
        paddle_l_x = 13'd100;  paddle_l_y = 13'd100;
        paddle_r_x = 13'd2256; paddle_r_y = 13'd1800;
        paddle_size = 13'd128;
        serve_pulse();
        do_ticks(118);
        check_ball("corner_hit", 2224, 1904);
        do_ticks(1);
        check_ball("corner_after", 2214, 1896);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ball_move.md
Name: ball_move

Overview:
Ball physics stage that sits directly downstream of the two paddle movers. It consumes both paddle centre positions and the shared half-length, and it owns the ball position, velocity and serve/score state machine. It advances the ball once per frame tick and resolves wall bounces, paddle hits and misses. Its position feeds the renderer, and its score pulses feed the scoreboard.

Parameters:
FIELD_W, 2560, playfield width in coordinate units; x range 0..FIELD_W-1
FIELD_H, 1920, playfield height; must match the paddle clamp range
BALL_R, 16, ball half-size (square ball)
PADDLE_HW, 16, paddle half-width in x
SPEED_INIT, 8, |vx| after every serve; |vy| is always SPEED_INIT
SPEED_STEP, 2, |vx| increment per paddle hit
SPEED_MAX, 32, |vx| saturation value
HOLD_TICKS, 60, ticks spent in SCORED before re-centering

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tick  in  1  one-cycle frame update strobe
serve  in  1  launch request; honoured only in IDLE
paddle_l_x  in  13  left paddle centre x
paddle_l_y  in  13  left paddle centre y
paddle_r_x  in  13  right paddle centre x
paddle_r_y  in  13  right paddle centre y
paddle_size  in  13  paddle half-length in y, shared by both paddles
ball_x  out  13  ball centre x
ball_y  out  13  ball centre y
in_play  out  1  high while in PLAY
score_l  out  1  one-cycle pulse: left player scores (right miss)
score_r  out  1  one-cycle pulse: right player scores (left miss)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; ball_x=FIELD_W/2 (1280); ball_y=FIELD_H/2 (960).
  - dir_x=+1, dir_y=+1; speed=SPEED_INIT.
  - score_l=0, score_r=0; hold counter cleared.
  - Reset asserted mid-PLAY or mid-SCORED takes effect immediately.
- States:
  - IDLE: ball held at centre. serve=1 moves to PLAY on the next clk edge; tick is not required. in_play becomes 1 on that same edge.
  - PLAY: on each clk with tick=1 compute nx = x ± speed and ny = y ± SPEED_INIT, then apply the resolution steps below. Registered outputs change on that edge (1-cycle latency from tick). No change when tick=0.
  - SCORED: ball frozen at its last position. Hold counter increments per tick. At HOLD_TICKS go to IDLE, re-centre, set speed=SPEED_INIT, and set dir_x toward the player who conceded.
- Arithmetic: all intermediates are 15-bit signed, so underflow below 0 never wraps. Outputs are always within 0..FIELD_W-1 / 0..FIELD_H-1.
- Y resolution:
  - if ny-BALL_R <= 0: y=BALL_R, dir_y=+1.
  - else if ny+BALL_R >= FIELD_H: y=FIELD_H-BALL_R, dir_y=-1.
  - else y=ny.
- X resolution, left side (dir_x=-1), using the resolved y:
  - Hit condition: x-BALL_R > lx+PADDLE_HW, nx-BALL_R <= lx+PADDLE_HW, and |y-ly| <= paddle_size+BALL_R.
  - On hit: x=lx+PADDLE_HW+BALL_R, dir_x=+1, speed=min(speed+SPEED_STEP, SPEED_MAX).
  - Else if nx-BALL_R <= 0: x=BALL_R, score_r pulses 1 cycle, go to SCORED.
- X resolution, right side: symmetric. The hit face is rx-PADDLE_HW; the miss boundary is FIELD_W; a miss pulses score_l.
- Other rules:
  - Wall and paddle events resolve on the same tick independently.
  - At most one score pulse per rally.
  - serve outside IDLE is ignored.
  - Paddle inputs are sampled only on tick cycles.

Decomposition:
- Shared package pong_pkg:
  - COORD_W=13, FIELD_W, FIELD_H.
  - Ball and paddle geometry constants.
  - Ball state enum {IDLE, PLAY, SCORED}.
  - Signed intermediate width (15).
- Sub-module ball_paddle_hit: combinational crossing/overlap test for one paddle face, instantiated twice (left, right).

Test Plan:
1. Reset mid-PLAY -> outputs immediately return to (1280,960), in_play=0, score pulses 0, with no clk edge needed.
2. serve=1 in IDLE, then one tick -> in_play=1; after the tick ball=(1288,968); serve during PLAY changes nothing.
3. Paddles parked away; 118 ticks from serve -> y=1904, dir_y flips; next tick y=1896.
4. paddle_r_x=2400, paddle_size=128, paddle_r_y driven equal to ball_y -> at x=2368 the ball reflects: next tick x=2358 (speed 10). Repeated hits saturate |vx| at 32.
5. paddle_r_y=200, ball at y≈960 -> no hit; score_l pulses exactly 1 cycle when x reaches 2544. state=SCORED, ball frozen; after 60 ticks ball=(1280,960), IDLE; next serve moves toward the right side.
6. Left-side miss -> score_r pulses once, x clamped to 16, no x wrap-around. Wall and paddle hit on the same tick -> both dir_x and dir_y flip.
